// File: rtl/track_view_multi_pkg.sv
// Shared types and constants for the multi-kart track renderer:
// tile encodings, RGB444 palette, kart colours and the camera clamp helper.
package track_view_pkg;

   typedef enum logic [1:0] {
      TILE_GRASS  = 2'd0,
      TILE_ROAD   = 2'd1,
      TILE_WALL   = 2'd2,
      TILE_FINISH = 2'd3
   } tile_t;

   localparam logic [11:0] COLOR_GRASS        = 12'h0A0;
   localparam logic [11:0] COLOR_ROAD         = 12'h777;
   localparam logic [11:0] COLOR_WALL         = 12'h840;
   localparam logic [11:0] COLOR_FINISH_LIGHT = 12'hFFF;
   localparam logic [11:0] COLOR_FINISH_DARK  = 12'h000;

   localparam logic [11:0] KART_COLORS [8] = '{
      12'hF00, 12'h00F, 12'hFF0, 12'hF0F,
      12'h0FF, 12'hF80, 12'h08F, 12'hF8C
   };

   // Saturate a signed camera coordinate into [0, hi].
   function automatic logic [10:0] clamp(input logic signed [12:0] val,
                                         input logic signed [12:0] hi);
      if (val < 13'sd0)
         return 11'd0;
      else if (val > hi)
         return hi[10:0];
      else
         return val[10:0];
   endfunction

endpackage

// File: rtl/track_view_multi_if.sv
// Video-side bundle: screen counters and kart state in, rendered pixel out.
interface track_view_multi_if #(
   parameter int NUM_KARTS = 4
);
   logic [10:0]              hcount_in;
   logic [9:0]               vcount_in;
   logic [NUM_KARTS*11-1:0]  kart_x_in;
   logic [NUM_KARTS*11-1:0]  kart_y_in;
   logic [NUM_KARTS-1:0]     kart_en_in;
   logic [2:0]               camera_sel_in;
   logic [11:0]              pixel_out;

   modport master (
      output hcount_in, vcount_in, kart_x_in, kart_y_in, kart_en_in, camera_sel_in,
      input  pixel_out
   );

   modport slave (
      input  hcount_in, vcount_in, kart_x_in, kart_y_in, kart_en_in, camera_sel_in,
      output pixel_out
   );
endinterface

// File: rtl/track_view_multi_rom.sv
// Track tile map with a registered one-cycle read. The layout is a walled
// square circuit with a road ring and a checkered finish line on the left leg.
module track_tile_rom
   import track_view_pkg::*;
#(
   parameter int MAP_W  = 128,
   parameter int ADDR_W = 14
) (
   input  logic              clk_in,
   input  logic [ADDR_W-1:0] i_addr,
   output tile_t             o_tile
);

   localparam int IDX_W = ADDR_W / 2;
   localparam int EDGE  = MAP_W - 1;

   function automatic tile_t tile_at(input logic [IDX_W-1:0] row_bits,
                                     input logic [IDX_W-1:0] col_bits);
      int  r;
      int  c;
      logic road_row;
      logic road_col;
      r = int'(row_bits);
      c = int'(col_bits);
      road_row = ((r >= 8 && r <= 15) || (r >= EDGE - 15 && r <= EDGE - 8))
                 && c >= 8 && c <= EDGE - 8;
      road_col = ((c >= 8 && c <= 15) || (c >= EDGE - 15 && c <= EDGE - 8))
                 && r >= 8 && r <= EDGE - 8;
      if (r == 0 || r == EDGE || c == 0 || c == EDGE)
         return TILE_WALL;
      else if (c >= 8 && c <= 15 && r >= MAP_W/2 - 2 && r <= MAP_W/2 + 1)
         return TILE_FINISH;
      else if (road_row || road_col)
         return TILE_ROAD;
      else
         return TILE_GRASS;
   endfunction

   always_ff @(posedge clk_in) begin
      o_tile <= tile_at(i_addr[ADDR_W-1:IDX_W], i_addr[IDX_W-1:0]);
   end

endmodule

// File: rtl/track_view_multi.sv
// Three-stage track renderer: camera-relative world coordinates, tile lookup
// and kart hit test, then colour compositing with blanking.
module track_view_multi
   import track_view_pkg::*;
#(
   parameter int NUM_KARTS  = 4,
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int TRACK_SIZE = 2048,
   parameter int TILE_SIZE  = 16,
   parameter int KART_SIZE  = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   track_view_multi_if.slave tv
);

   localparam int TILE_BITS  = $clog2(TILE_SIZE);
   localparam int TRACK_BITS = $clog2(TRACK_SIZE);
   localparam int IDX_W      = TRACK_BITS - TILE_BITS;
   localparam int MAP_W      = TRACK_SIZE / TILE_SIZE;

   localparam logic [10:0]        H_ACT = 11'(H_ACTIVE);
   localparam logic [9:0]         V_ACT = 10'(V_ACTIVE);
   localparam logic [11:0]        KSZ   = 12'(KART_SIZE);
   localparam logic [3:0]         NK    = 4'(NUM_KARTS);
   localparam logic signed [12:0] X_OFF = 13'(KART_SIZE/2 - H_ACTIVE/2);
   localparam logic signed [12:0] Y_OFF = 13'(KART_SIZE/2 - V_ACTIVE/2);
   localparam logic signed [12:0] X_MAX = 13'(TRACK_SIZE - H_ACTIVE);
   localparam logic signed [12:0] Y_MAX = 13'(TRACK_SIZE - V_ACTIVE);

   // Frame-stable shadow state
   logic [10:0]             r_cam_x, r_cam_y;
   logic [NUM_KARTS*11-1:0] r_kx, r_ky;
   logic [NUM_KARTS-1:0]    r_en;

   // Pipeline registers
   logic [11:0] r_wx, r_wy;
   logic        r_blank1, r_blank2, r_chk2, r_hit2;
   logic [2:0]  r_hit_idx2;
   logic [11:0] r_pixel;

   logic                 w_latch, w_blank;
   logic [2:0]           w_sel;
   logic [10:0]          w_sel_x, w_sel_y, w_cam_x, w_cam_y;
   logic [11:0]          w_wx, w_wy;
   logic [NUM_KARTS-1:0] w_hit;
   logic                 w_hit_any;
   logic [2:0]           w_hit_idx;
   logic [11:0]          w_track_color;
   tile_t                w_tile;

   assign w_latch = (tv.hcount_in == 11'd0) && (tv.vcount_in == V_ACT);
   assign w_blank = (tv.hcount_in >= H_ACT) || (tv.vcount_in >= V_ACT);
   assign w_sel   = ({1'b0, tv.camera_sel_in} < NK) ? tv.camera_sel_in : 3'd0;

   always_comb begin
      w_sel_x = '0;
      w_sel_y = '0;
      for (int i = 0; i < NUM_KARTS; i++) begin
         if (w_sel == 3'(i)) begin
            w_sel_x = tv.kart_x_in[i*11 +: 11];
            w_sel_y = tv.kart_y_in[i*11 +: 11];
         end
      end
   end

   assign w_cam_x = clamp($signed({2'b00, w_sel_x}) + X_OFF, X_MAX);
   assign w_cam_y = clamp($signed({2'b00, w_sel_y}) + Y_OFF, Y_MAX);
   assign w_wx    = {1'b0, r_cam_x} + {1'b0, tv.hcount_in};
   assign w_wy    = {1'b0, r_cam_y} + {2'b00, tv.vcount_in};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KARTS; gi++) begin : g_kart_hit
         logic [11:0] w_kx, w_ky;
         assign w_kx = {1'b0, r_kx[gi*11 +: 11]};
         assign w_ky = {1'b0, r_ky[gi*11 +: 11]};
         assign w_hit[gi] = r_en[gi]
                            && (w_kx <= r_wx) && (r_wx < w_kx + KSZ)
                            && (w_ky <= r_wy) && (r_wy < w_ky + KSZ);
      end
   endgenerate

   // Descending scan so the lowest-index hit wins
   always_comb begin
      w_hit_idx = '0;
      for (int i = NUM_KARTS - 1; i >= 0; i--) begin
         if (w_hit[i])
            w_hit_idx = 3'(i);
      end
   end
   assign w_hit_any = |w_hit;

   track_tile_rom #(
      .MAP_W  (MAP_W),
      .ADDR_W (2 * IDX_W)
   ) u_rom (
      .clk_in (clk_in),
      .i_addr ({r_wy[TRACK_BITS-1:TILE_BITS], r_wx[TRACK_BITS-1:TILE_BITS]}),
      .o_tile (w_tile)
   );

   always_comb begin
      w_track_color = COLOR_GRASS;
      unique case (w_tile)
         TILE_GRASS:  w_track_color = COLOR_GRASS;
         TILE_ROAD:   w_track_color = COLOR_ROAD;
         TILE_WALL:   w_track_color = COLOR_WALL;
         TILE_FINISH: w_track_color = r_chk2 ? COLOR_FINISH_LIGHT : COLOR_FINISH_DARK;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_cam_x    <= '0;
         r_cam_y    <= '0;
         r_kx       <= '0;
         r_ky       <= '0;
         r_en       <= '0;
         r_wx       <= '0;
         r_wy       <= '0;
         r_blank1   <= 1'b1;
         r_blank2   <= 1'b1;
         r_chk2     <= 1'b0;
         r_hit2     <= 1'b0;
         r_hit_idx2 <= '0;
         r_pixel    <= '0;
      end else begin
         if (w_latch) begin
            r_cam_x <= w_cam_x;
            r_cam_y <= w_cam_y;
            r_kx    <= tv.kart_x_in;
            r_ky    <= tv.kart_y_in;
            r_en    <= tv.kart_en_in;
         end
         r_wx       <= w_wx;
         r_wy       <= w_wy;
         r_blank1   <= w_blank;
         r_blank2   <= r_blank1;
         r_chk2     <= r_wx[3] ^ r_wy[3];
         r_hit2     <= w_hit_any;
         r_hit_idx2 <= w_hit_idx;
         if (r_blank2)
            r_pixel <= 12'h000;
         else if (r_hit2)
            r_pixel <= KART_COLORS[r_hit_idx2];
         else
            r_pixel <= w_track_color;
      end
   end

   assign tv.pixel_out = r_pixel;

endmodule

// File: tb/tb_track_view_multi.sv
// Directed bench for track_view_multi: reset, blanking, camera clamp, finish
// checker, kart priority, frame latch, select fallback and mid-frame reset.
module tb_track_view_multi;

   localparam logic [11:0] GRASS = 12'h0A0;
   localparam logic [11:0] ROAD  = 12'h777;
   localparam logic [11:0] WALL  = 12'h840;
   localparam logic [11:0] K0    = 12'hF00;
   localparam logic [11:0] K1    = 12'h00F;
   localparam logic [11:0] K2    = 12'hFF0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   track_view_multi_if #(.NUM_KARTS(4)) tv ();

   track_view_multi #(
      .NUM_KARTS  (4),
      .H_ACTIVE   (1280),
      .V_ACTIVE   (720),
      .TRACK_SIZE (2048),
      .TILE_SIZE  (16),
      .KART_SIZE  (16)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .tv     (tv)
   );

   task automatic check_px(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: pixel_out=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: pixel_out=%h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_kart(input int idx, input logic [10:0] x, input logic [10:0] y);
      tv.kart_x_in[idx*11 +: 11] = x;
      tv.kart_y_in[idx*11 +: 11] = y;
   endtask

   task automatic latch();
      tv.hcount_in = 11'd0;
      tv.vcount_in = 10'd720;
      tick();
   endtask

   task automatic pix(input string tag, input logic [10:0] h, input logic [9:0] v,
                      input logic [11:0] exp);
      tv.hcount_in = h;
      tv.vcount_in = v;
      repeat (3) tick();
      check_px(tag, tv.pixel_out, exp);
   endtask

   initial begin
      tv.hcount_in     = '0;
      tv.vcount_in     = '0;
      tv.kart_x_in     = '0;
      tv.kart_y_in     = '0;
      tv.kart_en_in    = '0;
      tv.camera_sel_in = '0;

      // Reset held two cycles, then a pipelined sweep across the blanking edge
      tick();
      check_px("reset_c1", tv.pixel_out, 12'h000);
      tick();
      check_px("reset_c2", tv.pixel_out, 12'h000);
      rst = 1'b0;
      tv.hcount_in = 11'd1279; tick();
      tv.hcount_in = 11'd1280; tick();
      tv.hcount_in = 11'd1281; tick();
      check_px("h1279_wall", tv.pixel_out, WALL);
      tick();
      check_px("h1280_blank", tv.pixel_out, 12'h000);
      tick();
      check_px("h1281_blank", tv.pixel_out, 12'h000);

      // Camera clamped at the far corner: cam=(768,1328)
      set_kart(0, 11'd1960, 11'd1960);
      latch();
      pix("clampmax_0_0_grass", 11'd0, 10'd0, GRASS);
      pix("clampmax_1024_0_road", 11'd1024, 10'd0, ROAD);
      pix("clampmax_corner_wall", 11'd1279, 10'd719, WALL);

      // Camera clamped at the origin, kart 0 drawn
      set_kart(0, 11'd224, 11'd224);
      tv.kart_en_in = 4'b0001;
      latch();
      pix("clamp0_0_0_wall", 11'd0, 10'd0, WALL);
      pix("clamp0_130_300_road", 11'd130, 10'd300, ROAD);
      pix("clamp0_kart0", 11'd230, 10'd230, K0);

      // Unclamped y camera (0,648) over the finish line checker
      set_kart(0, 11'd0, 11'd1000);
      tv.kart_en_in = 4'b0000;
      latch();
      pix("finish_light", 11'd130, 10'd352, 12'hFFF);
      pix("finish_dark", 11'd136, 10'd352, 12'h000);

      // Priority between overlapping karts
      set_kart(0, 11'd100, 11'd100);
      set_kart(2, 11'd100, 11'd100);
      tv.kart_en_in = 4'b0101;
      latch();
      pix("prio_k0_over_k2", 11'd105, 10'd105, K0);
      tv.kart_en_in = 4'b0100;
      latch();
      pix("prio_k2_alone", 11'd105, 10'd105, K2);

      // Mid-frame input changes wait for the next latch
      set_kart(1, 11'd50, 11'd50);
      tv.kart_en_in = 4'b0010;
      latch();
      pix("latch_k1_before", 11'd55, 10'd55, K1);
      set_kart(1, 11'd300, 11'd50);
      tv.hcount_in = 11'd0;
      tv.vcount_in = 10'd10;
      tick();
      pix("latch_k1_held", 11'd55, 10'd55, K1);
      pix("latch_new_pos_track", 11'd305, 10'd55, GRASS);
      latch();
      pix("latch_k1_moved", 11'd305, 10'd55, K1);
      pix("latch_old_pos_track", 11'd55, 10'd55, GRASS);

      // Out-of-range select falls back to kart 0, not kart 6&3
      set_kart(0, 11'd1960, 11'd1960);
      set_kart(2, 11'd224, 11'd224);
      tv.kart_en_in = 4'b0000;
      tv.camera_sel_in = 3'd6;
      latch();
      pix("sel6_follows_k0", 11'd1024, 10'd0, ROAD);

      // Mid-frame reset with a kart on screen
      tv.camera_sel_in = 3'd0;
      set_kart(1, 11'd800, 11'd1400);
      tv.kart_en_in = 4'b0011;
      latch();
      pix("prereset_k1", 11'd37, 10'd77, K1);
      tv.hcount_in = 11'd400;
      tv.vcount_in = 10'd300;
      rst = 1'b1;
      #1;
      check_px("midrst_async", tv.pixel_out, 12'h000);
      tick();
      check_px("midrst_held", tv.pixel_out, 12'h000);
      rst = 1'b0;
      tv.hcount_in = 11'd130;
      tv.vcount_in = 10'd300;
      tick();
      check_px("postrst_c1", tv.pixel_out, 12'h000);
      tv.hcount_in = 11'd5;
      tv.vcount_in = 10'd5;
      tick();
      check_px("postrst_c2", tv.pixel_out, 12'h000);
      tick();
      check_px("postrst_cam0_road", tv.pixel_out, ROAD);
      tick();
      check_px("postrst_no_kart", tv.pixel_out, WALL);
      latch();
      pix("postrst_latch_k1", 11'd37, 10'd77, K1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
